// File: rtl/cf_math_pkg.sv
// ============================================================================
// cf_math_pkg : shared width helpers for index and counter sizing.
// Rev 1.0
// ============================================================================
`default_nettype none

package cf_math_pkg;

  // Width of an index into num_idx items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? int'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_sel_fifo.sv
// ============================================================================
// stream_sel_fifo : payload+select FIFO feeding one stream_xbar input.
// Rev 1.0
// ============================================================================
`default_nettype none

module stream_sel_fifo
  import cf_math_pkg::*;
#(
  parameter int unsigned NumOut   = 4,
  parameter int unsigned Depth    = 4,
  parameter type         payload_t = logic,
  parameter int unsigned SelWidth = idx_width(NumOut),
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  payload_t                           data_i,
  input  logic [SelWidth-1:0]                sel_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output payload_t                           data_o,
  output logic [SelWidth-1:0]                sel_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [CntWidth-1:0]                usage_o,
  output logic [NumOut-1:0][CntWidth-1:0]    dest_cnt_o
);

  localparam int unsigned PtrWidth = idx_width(Depth);

  typedef logic [PtrWidth-1:0] ptr_t;
  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [SelWidth-1:0] sel_t;

  payload_t r_data [Depth];
  sel_t     r_sel  [Depth];
  ptr_t     r_rptr;
  ptr_t     r_wptr;
  cnt_t     r_usage;

  logic w_push;
  logic w_pop;
  ptr_t w_rptr_nxt;
  ptr_t w_wptr_nxt;

  // Ready looks only at occupancy, so a same-cycle pop never frees a slot.
  assign ready_o = !flush_i && (r_usage < cnt_t'(Depth));
  assign valid_o = (r_usage != '0);
  assign data_o  = r_data[r_rptr];
  assign sel_o   = r_sel[r_rptr];
  assign usage_o = r_usage;

  assign w_push = valid_i && ready_o;
  assign w_pop  = valid_o && ready_i;

  assign w_rptr_nxt = (r_rptr == ptr_t'(Depth - 1)) ? '0 : ptr_t'(r_rptr + 1'b1);
  assign w_wptr_nxt = (r_wptr == ptr_t'(Depth - 1)) ? '0 : ptr_t'(r_wptr + 1'b1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_data[i] <= '0;
        r_sel[i]  <= '0;
      end
    end else if (w_push) begin
      r_data[r_wptr] <= data_i;
      r_sel[r_wptr]  <= sel_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_usage <= '0;
    end else if (flush_i) begin
      // A consumer-side pop in this cycle is dropped along with everything else.
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_usage <= '0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      if (w_push && !w_pop)      r_usage <= cnt_t'(r_usage + 1'b1);
      else if (w_pop && !w_push) r_usage <= cnt_t'(r_usage - 1'b1);
    end
  end

  for (genvar k = 0; k < int'(NumOut); k++) begin : g_dest
    cnt_t r_cnt;
    logic w_inc;
    logic w_dec;

    assign w_inc = w_push && (sel_i == sel_t'(k));
    assign w_dec = w_pop && (sel_o == sel_t'(k));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_cnt <= '0;
      end else if (flush_i) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= cnt_t'(r_cnt + 1'b1);
      end else if (w_dec && !w_inc) begin
        r_cnt <= cnt_t'(r_cnt - 1'b1);
      end
    end

    assign dest_cnt_o[k] = r_cnt;
  end

`ifndef SYNTHESIS
  int w_cnt_sum;
  always_comb begin
    w_cnt_sum = 0;
    for (int k = 0; k < int'(NumOut); k++) w_cnt_sum += int'(dest_cnt_o[k]);
  end

  a_sel_range: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_i |-> (32'(sel_i) < NumOut));

  a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o) && $stable(sel_o)));

  a_cnt_sum: assert property (@(posedge clk_i) disable iff (rst_i)
    w_cnt_sum == int'(r_usage));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && (r_usage == cnt_t'(Depth))));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_pop && (r_usage == '0)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_sel_fifo.sv
// ============================================================================
// tb_stream_sel_fifo : queue-model bench for stream_sel_fifo (Depth 4 and 3).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_sel_fifo;

  typedef logic [7:0] pl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic valid = 1'b0;
  logic ready = 1'b0;
  pl_t  data = '0;
  logic [1:0] sel = '0;

  logic            rdy_a, vld_a, rdy_b, vld_b;
  pl_t             dat_a, dat_b;
  logic [1:0]      sel_a, sel_b;
  logic [2:0]      use_a;
  logic [1:0]      use_b;
  logic [3:0][2:0] cnt_a;
  logic [3:0][1:0] cnt_b;

  stream_sel_fifo #(.NumOut(4), .Depth(4), .payload_t(pl_t)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .data_i(data), .sel_i(sel), .valid_i(valid), .ready_o(rdy_a),
    .data_o(dat_a), .sel_o(sel_a), .valid_o(vld_a), .ready_i(ready),
    .usage_o(use_a), .dest_cnt_o(cnt_a)
  );

  stream_sel_fifo #(.NumOut(4), .Depth(3), .payload_t(pl_t)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .data_i(data), .sel_i(sel), .valid_i(valid), .ready_o(rdy_b),
    .data_o(dat_b), .sel_o(sel_b), .valid_o(vld_b), .ready_i(ready),
    .usage_o(use_b), .dest_cnt_o(cnt_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a FIFO is a queue of {sel, data}; everything else is derived from it.
  bit [9:0] qa[$];
  bit [9:0] qb[$];

  task automatic model_chk(input string nm, input int depth, input bit [9:0] q[$],
                           input logic r, input logic v, input logic [31:0] u,
                           input pl_t d, input logic [1:0] s, input logic [31:0] c [4]);
    int n;
    chk({nm, ".ready"}, 32'(r), 32'(!flush && (q.size() < depth)));
    chk({nm, ".valid"}, 32'(v), 32'(q.size() != 0));
    chk({nm, ".usage"}, u, 32'(q.size()));
    if (q.size() != 0) begin
      chk({nm, ".data"}, 32'(d), 32'(q[0][7:0]));
      chk({nm, ".sel"},  32'(s), 32'(q[0][9:8]));
    end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      foreach (q[i]) if (int'(q[i][9:8]) == k) n++;
      chk($sformatf("%s.dest_cnt[%0d]", nm, k), c[k], 32'(n));
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] ca [4];
    logic [31:0] cb [4];
    bit push_a, pop_a, push_b, pop_b;
    for (int k = 0; k < 4; k++) begin
      ca[k] = 32'(cnt_a[k]);
      cb[k] = 32'(cnt_b[k]);
    end
    if (rst) begin
      qa.delete();
      qb.delete();
      chk("A.rst_ready", 32'(rdy_a), 32'(!flush));
      chk("A.rst_valid", 32'(vld_a), 0);
      chk("A.rst_usage", 32'(use_a), 0);
      chk("B.rst_ready", 32'(rdy_b), 32'(!flush));
      chk("B.rst_valid", 32'(vld_b), 0);
      chk("B.rst_usage", 32'(use_b), 0);
    end else begin
      model_chk("A", 4, qa, rdy_a, vld_a, 32'(use_a), dat_a, sel_a, ca);
      model_chk("B", 3, qb, rdy_b, vld_b, 32'(use_b), dat_b, sel_b, cb);
      push_a = valid && !flush && (qa.size() < 4);
      pop_a  = ready && (qa.size() != 0);
      push_b = valid && !flush && (qb.size() < 3);
      pop_b  = ready && (qb.size() != 0);
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (pop_a)  void'(qa.pop_front());
        if (push_a) qa.push_back({sel, data});
        if (pop_b)  void'(qb.pop_front());
        if (push_b) qb.push_back({sel, data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  fill_sel [4];
    logic [19:0] vp;
    logic [19:0] rp;
    fill_sel = '{2'd0, 2'd1, 2'd1, 2'd3};
    vp = 20'hB5D3A;
    rp = 20'h6E9C5;

    // Reset held for five edges.
    repeat (5) step();
    chk("reset_ready", 32'(rdy_a), 1);
    chk("reset_valid", 32'(vld_a), 0);
    chk("reset_usage", 32'(use_a), 0);
    chk("reset_cnt",   32'(cnt_a), 0);
    chk("reset_data",  32'(dat_a), 0);
    chk("reset_sel",   32'(sel_a), 0);
    rst = 1'b0;

    // Fill with sinks stalled.
    ready = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel  = fill_sel[i];
      data = pl_t'(8'hA0 + i);
      step();
    end
    valid = 1'b0;
    chk("fill_usage", 32'(use_a), 4);
    chk("fill_ready", 32'(rdy_a), 0);
    chk("fill_cnt",   32'(cnt_a), 32'({3'd1, 3'd0, 3'd2, 3'd1}));
    chk("fill_head_data", 32'(dat_a), 32'h0A0);
    chk("fill_head_sel",  32'(sel_a), 0);
    chk("fill_usage_d3",  32'(use_b), 3);

    // Drain in order.
    ready = 1'b1;
    step();
    chk("drain_ready_rise", 32'(rdy_a), 1);
    chk("drain_usage", 32'(use_a), 3);
    chk("drain_head_data", 32'(dat_a), 32'h0A1);
    repeat (3) step();
    chk("drain_empty_usage", 32'(use_a), 0);
    chk("drain_empty_cnt",   32'(cnt_a), 0);
    chk("drain_empty_valid", 32'(vld_a), 0);
    ready = 1'b0;

    // Simultaneous push/pop at usage 2 with matching selects.
    valid = 1'b1;
    sel = 2'd2; data = 8'hB0; step();
    sel = 2'd0; data = 8'hB1; step();
    sel = 2'd2; data = 8'hB2; ready = 1'b1;
    step();
    chk("pushpop_usage",  32'(use_a), 2);
    chk("pushpop_cnt2",   32'(cnt_a[2]), 1);
    chk("pushpop_usage_d3", 32'(use_b), 2);
    for (int i = 0; i < 10; i++) begin
      sel  = 2'(i);
      data = pl_t'(8'hC0 + i);
      step();
    end
    chk("wrap_usage", 32'(use_a), 2);
    chk("wrap_usage_d3", 32'(use_b), 2);
    valid = 1'b0;
    ready = 1'b0;

    // Flush at usage 3, with a push and a pop offered in the same cycle.
    valid = 1'b1; sel = 2'd3; data = 8'hD0; step();
    flush = 1'b1; sel = 2'd1; data = 8'hD1; ready = 1'b1;
    #1;
    chk("flush_pre_usage", 32'(use_a), 3);
    chk("flush_refuse_a", 32'(rdy_a), 0);
    chk("flush_refuse_b", 32'(rdy_b), 0);
    step();
    flush = 1'b0; valid = 1'b0; ready = 1'b0;
    chk("flush_usage", 32'(use_a), 0);
    chk("flush_cnt",   32'(cnt_a), 0);
    chk("flush_valid", 32'(vld_a), 0);

    // Asynchronous reset with three entries queued.
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel  = 2'(i);
      data = pl_t'(8'hE0 + i);
      step();
    end
    valid = 1'b0;
    chk("prereset_usage", 32'(use_a), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_usage", 32'(use_a), 0);
    chk("async_rst_valid", 32'(vld_a), 0);
    chk("async_rst_cnt",   32'(cnt_a), 0);
    chk("async_rst_usage_d3", 32'(use_b), 0);
    step();
    rst = 1'b0;

    // Mixed traffic from fixed valid/ready patterns, then drain.
    for (int i = 0; i < 20; i++) begin
      valid = vp[i];
      ready = rp[i];
      sel   = 2'(i * 3);
      data  = pl_t'(8'hF0 + i);
      step();
    end
    valid = 1'b0;
    ready = 1'b1;
    repeat (5) step();
    chk("final_usage", 32'(use_a), 0);
    chk("final_usage_d3", 32'(use_b), 0);
    ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
